counter_cmd_sequencer: RTL and testbench
========================================

Name: counter_cmd_sequencer

Overview:
Command sequencer and arbiter that shares one 16-bit up/down loadable counter between two requesters. Each requester issues LOAD, COUNT_UP or COUNT_DOWN commands over a valid/ready handshake. The block grants one command at a time round-robin, drives the counter's load, enable and direction controls for the required number of cycles, and returns a completion pulse with the final count and a wrap flag. It sits between the requester logic and the counter datapath.

Parameters:
WIDTH, 16, counter data width and command argument width.

Ports:
pclk  input  1  clock, rising edge.
prst  input  1  asynchronous active-low reset.
req0_valid  input  1  requester 0 command valid.
req0_op  input  2  requester 0 opcode: 00 LOAD, 01 COUNT_UP, 10 COUNT_DOWN, 11 reserved.
req0_arg  input  WIDTH  requester 0 argument: load value for LOAD, step count for COUNT_*.
req0_ready  output  1  requester 0 command accepted this cycle.
req1_valid, req1_op, req1_arg, req1_ready  as requester 0.
cnt_ld_n  output  1  counter load, active-low.
cnt_enb  output  1  counter count enable.
cnt_updn  output  1  counter direction, 1 = up.
cnt_data_in  output  WIDTH  counter load value.
cnt_data_out  input  WIDTH  current counter value.
done  output  1  one-cycle completion pulse.
done_id  output  1  requester index of the completed command.
done_val  output  WIDTH  counter value at completion.
done_wrap  output  1  counter wrapped during the command.
done_err  output  1  reserved opcode was rejected.

Behaviour:
- Reset is asynchronous on prst low. Reset values: state IDLE; cnt_ld_n=1; cnt_enb=0; cnt_updn=0; cnt_data_in=0; done=0; done_id=0; done_val=0; done_wrap=0; done_err=0; RR pointer favours req0.
- Counter contract, relied on by this block: at the rising pclk edge it loads when ld_n=0, counts when ld_n=1 and enb=1 (+1 if updn=1, else -1, modulo 2^WIDTH), and holds otherwise.
- All counter controls and done* outputs are registered. reqN_ready is combinational: it is high only in IDLE, for the granted requester.
- Arbitration happens in IDLE. If only one valid is high, that requester is granted. If both are high, the requester selected by the RR pointer is granted, and after acceptance the pointer moves to the other requester. Only one ready is high per cycle. A command is accepted when valid and ready are both high at the rising edge; op, arg and id are latched then.
- FSM states: IDLE, LOAD, COUNT, DONE.
  - IDLE to LOAD when op=LOAD.
  - IDLE to COUNT when op=COUNT_* and arg!=0.
  - IDLE to DONE when op=COUNT_* and arg==0 (zero steps; counter untouched), or when op=11 (done_err=1; counter untouched).
  - LOAD: cnt_ld_n=0 and cnt_data_in=arg for exactly 1 cycle, cnt_enb=0, then DONE.
  - COUNT: cnt_enb=1 and cnt_updn=(op==COUNT_UP) for exactly arg cycles. An internal remaining-steps register is decremented each cycle; the FSM leaves COUNT when it reaches 1. arg=16'hFFFF gives 65535 enable cycles.
  - DONE: counter controls idle. done=1 for 1 cycle with done_val=cnt_data_out sampled this cycle, plus done_id, done_wrap and done_err. Then IDLE. A new command is not accepted in the DONE cycle.
- Latency from the acceptance edge T: LOAD completes with done in cycle T+2. COUNT of N steps has enb high in cycles T+1..T+N and done in T+N+1. Zero-step and error commands have done in T+1.
- Wrap detection: in any COUNT cycle, wrap is set sticky if cnt_updn=1 and cnt_data_out=all-ones, or if cnt_updn=0 and cnt_data_out=0. It is cleared on acceptance of a new command.
- A valid deasserted before acceptance drops the request with no effect. Valid held while another command runs waits.
- Reset mid-command aborts it immediately: counter controls go idle, and no done is issued.

Test Plan:
- req0 LOAD arg=16'h1234 -> req0_ready high 1 cycle; cnt_ld_n low 1 cycle with cnt_data_in=16'h1234; done at T+2 with done_val=16'h1234, done_id=0.
- After load of 16'h0005, req1 COUNT_DOWN arg=7 -> cnt_enb high exactly 7 cycles; done_val=16'hFFFE, done_wrap=1, done_id=1.
- req0 and req1 both valid with COUNT_UP arg=1, held -> req0 served first, then req1; with both still valid, grants alternate 0,1,0,1.
- req0 COUNT_UP arg=0 -> done at T+1, done_val unchanged, cnt_enb never high; req1 op=11 -> done_err=1, counter unchanged.
- prst low in the middle of COUNT arg=100 -> all outputs at reset values asynchronously, no done pulse, RR pointer back to req0.
- Load 16'h0000, then COUNT_UP arg=16'hFFFF -> done_val=16'hFFFF, done_wrap=0; a further COUNT_UP arg=1 -> done_val=16'h0000, done_wrap=1.

Source files
------------

// File: rtl/counter_cmd_sequencer_if.sv
// Requester-side command handshake for the shared-counter sequencer.
// Two requesters each present valid/op/arg and see a ready back.
interface counter_cmd_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_arg;
    logic             req0_ready;
    logic             req1_valid;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_arg;
    logic             req1_ready;

    modport master (
        output req0_valid, req0_op, req0_arg, req1_valid, req1_op, req1_arg,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_op, req0_arg, req1_valid, req1_op, req1_arg,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/counter_cmd_sequencer.sv
// Round-robin command sequencer sharing one up/down loadable counter between
// two requesters; drives the counter controls and reports completion.
module counter_cmd_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                   pclk,
    input  logic                   prst,
    counter_cmd_sequencer_if.slave req,
    output logic                   cnt_ld_n,
    output logic                   cnt_enb,
    output logic                   cnt_updn,
    output logic [WIDTH-1:0]       cnt_data_in,
    input  logic [WIDTH-1:0]       cnt_data_out,
    output logic                   done,
    output logic                   done_id,
    output logic [WIDTH-1:0]       done_val,
    output logic                   done_wrap,
    output logic                   done_err
);
    typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_e;

    localparam logic [1:0]       OP_LOAD = 2'b00;
    localparam logic [1:0]       OP_UP   = 2'b01;
    localparam logic [1:0]       OP_ERR  = 2'b11;
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q;
    logic             rr_q, id_q, wrap_q;
    logic [WIDTH-1:0] rem_q;
    logic             ld_n_q, enb_q, updn_q;
    logic [WIDTH-1:0] data_in_q;
    logic             done_q, done_id_q, done_wrap_q, done_err_q;
    logic [WIDTH-1:0] done_val_q;

    logic             gnt_d, accept_d, both_d, wrap_d, fin_d;
    logic [1:0]       op_d;
    logic [WIDTH-1:0] arg_d, done_val_d;

    always_comb begin
        both_d   = req.req0_valid && req.req1_valid;
        gnt_d    = both_d ? rr_q : req.req1_valid;
        accept_d = (state_q == IDLE) && (req.req0_valid || req.req1_valid);
        op_d     = gnt_d ? req.req1_op  : req.req0_op;
        arg_d    = gnt_d ? req.req1_arg : req.req0_arg;
        wrap_d   = wrap_q | (enb_q & (updn_q ? (&cnt_data_out) : (~|cnt_data_out)));
        // done is registered, so capture the value the counter will hold after this edge
        if (!ld_n_q)
            done_val_d = data_in_q;
        else if (enb_q)
            done_val_d = updn_q ? cnt_data_out + ONE : cnt_data_out - ONE;
        else
            done_val_d = cnt_data_out;
        case (state_q)
            IDLE:    fin_d = accept_d && (op_d == OP_ERR || (op_d != OP_LOAD && arg_d == '0));
            LOAD:    fin_d = 1'b1;
            COUNT:   fin_d = (rem_q == ONE);
            default: fin_d = 1'b0;
        endcase
    end

    assign req.req0_ready = accept_d && !gnt_d;
    assign req.req1_ready = accept_d &&  gnt_d;

    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            id_q        <= 1'b0;
            wrap_q      <= 1'b0;
            rem_q       <= '0;
            ld_n_q      <= 1'b1;
            enb_q       <= 1'b0;
            updn_q      <= 1'b0;
            data_in_q   <= '0;
            done_q      <= 1'b0;
            done_id_q   <= 1'b0;
            done_val_q  <= '0;
            done_wrap_q <= 1'b0;
            done_err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (accept_d) begin
                    id_q   <= gnt_d;
                    wrap_q <= 1'b0;
                    rem_q  <= arg_d;
                    if (both_d) rr_q <= ~gnt_d;
                    if (op_d == OP_LOAD) begin
                        state_q   <= LOAD;
                        ld_n_q    <= 1'b0;
                        data_in_q <= arg_d;
                    end else if (fin_d) begin
                        state_q <= DONE;
                    end else begin
                        state_q <= COUNT;
                        enb_q   <= 1'b1;
                        updn_q  <= (op_d == OP_UP);
                    end
                end
                LOAD: begin
                    ld_n_q  <= 1'b1;
                    state_q <= DONE;
                end
                COUNT: begin
                    wrap_q <= wrap_d;
                    rem_q  <= rem_q - ONE;
                    if (fin_d) begin
                        enb_q   <= 1'b0;
                        updn_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (fin_d) begin
                done_q      <= 1'b1;
                done_id_q   <= (state_q == IDLE) ? gnt_d : id_q;
                done_val_q  <= done_val_d;
                done_wrap_q <= (state_q == IDLE) ? 1'b0 : wrap_d;
                done_err_q  <= (state_q == IDLE) && (op_d == OP_ERR);
            end
        end
    end

    assign cnt_ld_n    = ld_n_q;
    assign cnt_enb     = enb_q;
    assign cnt_updn    = updn_q;
    assign cnt_data_in = data_in_q;
    assign done        = done_q;
    assign done_id     = done_id_q;
    assign done_val    = done_val_q;
    assign done_wrap   = done_wrap_q;
    assign done_err    = done_err_q;
endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Randomized bench for counter_cmd_sequencer: a behavioural counter plus a
// transaction-level model of arbitration, latency, final value and wrap.
`timescale 1ns/1ps
module tb_counter_cmd_sequencer;
    localparam int W = 16;
    localparam logic [63:0] RST_VEC = 64'h40_0000_0000;

    logic pclk = 1'b0;
    logic prst = 1'b1;
    logic cnt_ld_n, cnt_enb, cnt_updn, done, done_id, done_wrap, done_err;
    logic [W-1:0] cnt_data_in, done_val;
    logic [W-1:0] cnt_q = '0;

    counter_cmd_sequencer_if #(.WIDTH(W)) rif ();

    counter_cmd_sequencer #(.WIDTH(W)) dut (
        .pclk        (pclk),
        .prst        (prst),
        .req         (rif.slave),
        .cnt_ld_n    (cnt_ld_n),
        .cnt_enb     (cnt_enb),
        .cnt_updn    (cnt_updn),
        .cnt_data_in (cnt_data_in),
        .cnt_data_out(cnt_q),
        .done        (done),
        .done_id     (done_id),
        .done_val    (done_val),
        .done_wrap   (done_wrap),
        .done_err    (done_err)
    );

    always #5 pclk = ~pclk;

    // the counter datapath this block controls
    always @(posedge pclk) begin
        if (!cnt_ld_n)    cnt_q <= cnt_data_in;
        else if (cnt_enb) cnt_q <= cnt_updn ? cnt_q + 16'd1 : cnt_q - 16'd1;
    end

    int n_tests = 0, n_fail = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {25'b0, cnt_ld_n, cnt_enb, cnt_updn, cnt_data_in, done, done_id,
                done_val, done_wrap, done_err};
    endfunction

    // transaction-level reference model
    bit          busy = 0, rr_m = 0, mknown = 0;
    bit          e_id, e_wrap, e_err;
    logic [1:0]  e_op;
    logic [15:0] e_arg, e_val, mval = '0;
    int          done_c, e_enb, e_ld, enb_n, ld_n, acc_total = 0;
    bit          acc_ids[$];

    always @(posedge pclk) cyc++;

    always @(negedge pclk) begin
        logic [1:0] eg;
        int s;
        if (!prst) begin
            busy = 0; rr_m = 0; mknown = 0;
        end else begin
            if (rif.req0_valid || rif.req1_valid) begin
                if (busy)                                eg = 2'b00;
                else if (rif.req0_valid && rif.req1_valid) eg = rr_m ? 2'b10 : 2'b01;
                else                                     eg = rif.req1_valid ? 2'b10 : 2'b01;
                chk("grant", {rif.req1_ready, rif.req0_ready}, eg);
                if (eg != 2'b00) begin
                    e_id  = eg[1];
                    e_op  = e_id ? rif.req1_op  : rif.req0_op;
                    e_arg = e_id ? rif.req1_arg : rif.req0_arg;
                    if (rif.req0_valid && rif.req1_valid) rr_m = ~e_id;
                    s = int'(e_arg);
                    e_err = (e_op == 2'b11); e_wrap = 0; e_val = mval;
                    e_enb = 0; e_ld = 0; done_c = cyc + 1;
                    case (e_op)
                        2'b00: begin e_val = e_arg; e_ld = 1; done_c = cyc + 2; end
                        2'b01: if (s > 0) begin
                            e_val  = 16'((int'(mval) + s) % 65536);
                            e_wrap = (int'(mval) + s) > 65535;
                            e_enb  = s; done_c = cyc + s + 1;
                        end
                        2'b10: if (s > 0) begin
                            e_val  = 16'((int'(mval) - s + 65536) % 65536);
                            e_wrap = s > int'(mval);
                            e_enb  = s; done_c = cyc + s + 1;
                        end
                        default: ;
                    endcase
                    busy = 1; enb_n = 0; ld_n = 0;
                    acc_total++;
                    acc_ids.push_back(e_id);
                end
            end
            if (cnt_enb) begin
                enb_n++;
                if (enb_n == 1) chk("updn", cnt_updn, e_op == 2'b01);
            end
            if (!cnt_ld_n) begin
                ld_n++;
                chk("ld_data", cnt_data_in, e_arg);
            end
            if (done || (busy && cyc == done_c)) begin
                chk("done_pulse", done, busy && cyc == done_c);
                if (done && busy && cyc == done_c) begin
                    chk("done_id", done_id, e_id);
                    chk("done_err", done_err, e_err);
                    chk("enb_cycles", enb_n, e_enb);
                    chk("ld_cycles", ld_n, e_ld);
                    if (mknown || e_op == 2'b00) chk("done_val", done_val, e_val);
                    if (mknown || e_op == 2'b00 || e_op == 2'b11) chk("done_wrap", done_wrap, e_wrap);
                end
                if (busy && cyc == done_c) begin
                    busy = 0; mval = e_val;
                    if (e_op == 2'b00) mknown = 1;
                end
            end
        end
    end

    task automatic set_req(input bit id, input bit v, input logic [1:0] op, input logic [15:0] arg);
        if (id) begin rif.req1_valid = v; rif.req1_op = op; rif.req1_arg = arg; end
        else    begin rif.req0_valid = v; rif.req0_op = op; rif.req0_arg = arg; end
    endtask

    task automatic wait_acc(input int target);
        int k = 0;
        while (acc_total < target && k < 300) begin @(posedge pclk); #1; k++; end
        chk("accept_wait", acc_total >= target, 1'b1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin @(posedge pclk); #1; k++; end
        chk("idle_wait", busy, 1'b0);
    endtask

    task automatic issue(input bit id, input logic [1:0] op, input logic [15:0] arg);
        int t;
        t = acc_total + 1;
        set_req(id, 1'b1, op, arg);
        wait_acc(t);
        set_req(id, 1'b0, op, arg);
        wait_idle(70000);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        set_req(0, 1'b0, 2'b00, 16'h0);
        set_req(1, 1'b0, 2'b00, 16'h0);
        #2 prst = 1'b0;
        repeat (3) @(posedge pclk);
        #1 chk("reset_outs", outs(), RST_VEC);
        prst = 1'b1;
        @(posedge pclk); #1;

        issue(0, 2'b00, 16'h1234);
        issue(0, 2'b00, 16'h0005);
        issue(1, 2'b10, 16'd7);

        // contested, held requests alternate
        t = acc_total;
        set_req(0, 1'b1, 2'b01, 16'd1);
        set_req(1, 1'b1, 2'b01, 16'd1);
        wait_acc(t + 5);
        set_req(0, 1'b0, 2'b01, 16'd1);
        set_req(1, 1'b0, 2'b01, 16'd1);
        wait_idle(100);
        chk("rr_order", {acc_ids[t], acc_ids[t+1], acc_ids[t+2], acc_ids[t+3], acc_ids[t+4]}, 5'b01010);

        issue(0, 2'b01, 16'd0);
        issue(1, 2'b11, 16'h55AA);
        chk("cnt_after_err", cnt_q, 16'h0003);

        // request dropped while another command is running
        t = acc_total + 1;
        set_req(0, 1'b1, 2'b01, 16'd10);
        wait_acc(t);
        set_req(0, 1'b0, 2'b01, 16'd10);
        set_req(1, 1'b1, 2'b00, 16'hDEAD);
        repeat (4) @(posedge pclk);
        #1 set_req(1, 1'b0, 2'b00, 16'hDEAD);
        wait_idle(100);
        repeat (3) @(posedge pclk);
        #1 chk("drop_cnt", cnt_q, 16'd13);

        // reset mid-command
        t = acc_total + 1;
        set_req(0, 1'b1, 2'b01, 16'd100);
        wait_acc(t);
        set_req(0, 1'b0, 2'b01, 16'd100);
        repeat (30) @(posedge pclk);
        #2 prst = 1'b0;
        #1 chk("rst_mid", outs(), RST_VEC);
        repeat (3) @(posedge pclk);
        #1 prst = 1'b1;
        repeat (4) @(posedge pclk);
        #1 chk("rst_no_done", {done, cnt_enb}, 2'b00);

        t = acc_total + 1;
        set_req(0, 1'b1, 2'b00, 16'h0A0A);
        set_req(1, 1'b1, 2'b00, 16'h0B0B);
        wait_acc(t);
        set_req(0, 1'b0, 2'b00, 16'h0A0A);
        set_req(1, 1'b0, 2'b00, 16'h0B0B);
        wait_idle(100);
        @(posedge pclk); #1 chk("rr_after_rst", cnt_q, 16'h0A0A);

        // full-range count and wrap at the top
        issue(0, 2'b00, 16'h0000);
        issue(0, 2'b01, 16'hFFFF);
        issue(1, 2'b01, 16'd1);

        for (int i = 0; i < 40; i++) begin
            bit          id;
            logic [1:0]  op;
            logic [15:0] arg;
            id = 1'($urandom_range(0, 1));
            op = 2'($urandom_range(0, 3));
            if (op == 2'b00) begin
                case ($urandom_range(0, 2))
                    0:       arg = 16'($urandom_range(0, 6));
                    1:       arg = 16'(16'hFFFF - 16'($urandom_range(0, 6)));
                    default: arg = 16'($urandom);
                endcase
            end else begin
                arg = 16'($urandom_range(0, 12));
            end
            issue(id, op, arg);
        end

        repeat (3) @(posedge pclk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
